// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the 5-stage 16-bit CPU pipeline.
//   WORD_W     : datapath / instruction width
//   NOP_INSTR  : bubble word inserted into pipeline registers
//   RESET_PC   : PC loaded on reset
//   fetch_state_e : fetch redirect state (RUN, PEND)
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int          WORD_W    = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    // PEND means a redirect was taken while the bus was busy and the
    // delay slot has not been fetched yet.
    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg
// Generic pipeline register holding {valid, instruction, pc}.
// Priority: hold_i > bubble_i > load_i; with none asserted it holds.
// A bubble clears valid and loads NOP_INSTR but keeps the stored pc.
// Ports:
//   clk, rst      : clock (rising edge), async active-low reset
//   hold_i        : keep current contents
//   bubble_i      : insert a NOP bubble
//   load_i        : capture instr_i / pc_i as a valid entry
//   instr_i, pc_i : incoming instruction and its pc value
//   valid_o, instr_o, pc_o : registered contents
// ---------------------------------------------------------------------------
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int          W       = WORD_W,
    parameter logic [15:0] NOP_VAL = cpu_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold_i,
    input  logic         bubble_i,
    input  logic         load_i,
    input  logic [W-1:0] instr_i,
    input  logic [W-1:0] pc_i,
    output logic         valid_o,
    output logic [W-1:0] instr_o,
    output logic [W-1:0] pc_o
);

    logic         r_valid;
    logic [W-1:0] r_instr;
    logic [W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_instr <= W'(NOP_VAL);
            r_pc    <= '0;
        end else if (hold_i) begin
            r_valid <= r_valid;
        end else if (bubble_i) begin
            r_valid <= 1'b0;
            r_instr <= W'(NOP_VAL);
        end else if (load_i) begin
            r_valid <= 1'b1;
            r_instr <= instr_i;
            r_pc    <= pc_i;
        end
    end

    assign valid_o = r_valid;
    assign instr_o = r_instr;
    assign pc_o    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// IF stage: owns the PC, drives the combinational instruction memory and
// fills the IF/ID register. Handles decode stalls, instruction-bus conflicts
// (imem_wait_i) and branch/jump redirects with one delay slot.
// Optional macro: FETCH_PERF_EN adds fetch_cnt_o / bubble_cnt_o counters.
// Ports:
//   clk, rst          : clock (rising edge), async active-low reset
//   pc_o              : fetch address (registered PC)
//   instr_i           : instruction word at pc_o, same cycle
//   imem_wait_i       : bus used by data access; instr_i invalid
//   stall_i           : hold PC and IF/ID
//   redirect_i        : taken branch/jump pulse from ID
//   redirect_pc_i     : redirect target
//   ifid_valid_o, ifid_instr_o, ifid_pc_o : IF/ID contents (pc is PC+STEP)
//   fetch_cnt_o, bubble_cnt_o (FETCH_PERF_EN) : saturating event counters
// ---------------------------------------------------------------------------
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [15:0] PC_STEP   = 16'd1,
    parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc_o,
    input  logic [15:0] instr_i,
    input  logic        imem_wait_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic        ifid_valid_o,
    output logic [15:0] ifid_instr_o,
    output logic [15:0] ifid_pc_o
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_cnt_o,
    output logic [15:0] bubble_cnt_o
`endif
);

    fetch_state_e r_state;
    fetch_state_e w_stateNext;
    logic [15:0]  r_pc;
    logic [15:0]  r_pendPc;
    logic [15:0]  w_pcNext;
    logic [15:0]  w_pendPcNext;
    logic [15:0]  w_pcInc;
    logic         w_advance;
    logic         w_bubble;

    assign w_advance = !stall_i && !imem_wait_i;
    assign w_bubble  = !stall_i &&  imem_wait_i;
    assign w_pcInc   = r_pc + PC_STEP;
    assign pc_o      = r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_pc     <= RESET_PC;
            r_pendPc <= 16'h0000;
        end else begin
            r_state  <= w_stateNext;
            r_pc     <= w_pcNext;
            r_pendPc <= w_pendPcNext;
        end
    end

    // A redirect seen during a bus bubble is parked in r_pendPc: the delay
    // slot at r_pc must still be fetched before jumping to the target.
    always_comb begin
        w_stateNext  = r_state;
        w_pcNext     = r_pc;
        w_pendPcNext = r_pendPc;
        if (w_bubble && redirect_i) begin
            w_pendPcNext = redirect_pc_i;
            w_stateNext  = PEND;
        end else if (w_advance) begin
            if (r_state == PEND) begin
                w_pcNext    = r_pendPc;
                w_stateNext = RUN;
            end else if (redirect_i) begin
                w_pcNext = redirect_pc_i;
            end else begin
                w_pcNext = w_pcInc;
            end
        end
    end

    ifid_reg #(
        .W       (16),
        .NOP_VAL (NOP_INSTR)
    ) u_ifid (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (stall_i),
        .bubble_i (w_bubble),
        .load_i   (w_advance),
        .instr_i  (instr_i),
        .pc_i     (w_pcInc),
        .valid_o  (ifid_valid_o),
        .instr_o  (ifid_instr_o),
        .pc_o     (ifid_pc_o)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] r_fetchCnt;
    logic [15:0] r_bubbleCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetchCnt  <= 16'h0000;
            r_bubbleCnt <= 16'h0000;
        end else begin
            if (w_advance && (r_fetchCnt != 16'hFFFF))
                r_fetchCnt <= r_fetchCnt + 16'd1;
            if (w_bubble && (r_bubbleCnt != 16'hFFFF))
                r_bubbleCnt <= r_bubbleCnt + 16'd1;
        end
    end

    assign fetch_cnt_o  = r_fetchCnt;
    assign bubble_cnt_o = r_bubbleCnt;
`endif

    // ID must not issue a second redirect before the parked one is taken.
    a_noRedirectInPend : assert property (
        @(posedge clk) disable iff (!rst)
        !((r_state == PEND) && redirect_i && !stall_i)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The instruction memory returns its own
// address as the instruction word (0xDEAD while the bus is busy).
// Optional macro: FETCH_PERF_EN also checks the performance counters.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pcOut;
    logic [15:0] instrIn;
    logic        imemWait = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirectPc = 16'h0000;
    logic        ifidValid;
    logic [15:0] ifidInstr;
    logic [15:0] ifidPc;
`ifdef FETCH_PERF_EN
    logic [15:0] fetchCnt;
    logic [15:0] bubbleCnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign instrIn = imemWait ? 16'hDEAD : pcOut;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc_o          (pcOut),
        .instr_i       (instrIn),
        .imem_wait_i   (imemWait),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirectPc),
        .ifid_valid_o  (ifidValid),
        .ifid_instr_o  (ifidInstr),
        .ifid_pc_o     (ifidPc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o   (fetchCnt),
        .bubble_cnt_o  (bubbleCnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive inputs, take one rising edge, and settle 1 time unit after it.
    task automatic applyStimulus(input logic st, input logic wt,
                                 input logic rd, input logic [15:0] tgt);
        stall      = st;
        imemWait   = wt;
        redirect   = rd;
        redirectPc = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfid(input string tag, input logic [15:0] pc,
                             input logic valid, input logic [15:0] instr,
                             input logic [15:0] ipc);
        checkOutput({tag, ".pc"},    pcOut, pc);
        checkOutput({tag, ".valid"}, {15'd0, ifidValid}, {15'd0, valid});
        checkOutput({tag, ".instr"}, ifidInstr, instr);
        checkOutput({tag, ".ifidpc"}, ifidPc, ipc);
    endtask

    initial begin
        // Reset state
        #12;
        checkIfid("reset", 16'h0000, 1'b0, 16'h0800, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Sequential fetch: instr@0..4 land in IF/ID, PC reaches 5
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
            checkIfid($sformatf("seq%0d", i), 16'(i + 1), 1'b1, 16'(i), 16'(i + 1));
        end

        // Stall for three edges at pc=5
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
            checkIfid($sformatf("stall%0d", i), 16'h0005, 1'b1, 16'h0004, 16'h0005);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkIfid("resume", 16'h0006, 1'b1, 16'h0005, 16'h0006);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkIfid("pre_redir", 16'h0008, 1'b1, 16'h0007, 16'h0008);

        // Plain redirect at pc=8: delay slot instr@8 captured, then target
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040);
        checkIfid("redir_slot", 16'h0040, 1'b1, 16'h0008, 16'h0009);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkIfid("redir_tgt", 16'h0041, 1'b1, 16'h0040, 16'h0041);

        // Return to pc=8, then redirect during a bus bubble
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0008);
        checkIfid("back8", 16'h0008, 1'b1, 16'h0041, 16'h0042);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040);
        checkIfid("pend_bubble", 16'h0008, 1'b0, 16'h0800, 16'h0042);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkIfid("pend_slot", 16'h0040, 1'b1, 16'h0008, 16'h0009);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkIfid("pend_tgt", 16'h0041, 1'b1, 16'h0040, 16'h0041);

        // PC wrap at 0xFFFF
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
        checkIfid("to_ffff", 16'hFFFF, 1'b1, 16'h0041, 16'h0042);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkIfid("wrap", 16'h0000, 1'b1, 16'hFFFF, 16'h0000);

`ifdef FETCH_PERF_EN
        checkOutput("fetch_cnt", fetchCnt, 16'd15);
        checkOutput("bubble_cnt", bubbleCnt, 16'd1);
`endif

        // Enter PEND, then pulse reset asynchronously mid-cycle
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040);
        checkIfid("pend2", 16'h0000, 1'b0, 16'h0800, 16'h0000);
        redirect = 1'b0;
        imemWait = 1'b0;
        rst      = 1'b0;
        #1;
        checkIfid("async_rst", 16'h0000, 1'b0, 16'h0800, 16'h0000);
`ifdef FETCH_PERF_EN
        checkOutput("fetch_cnt_rst", fetchCnt, 16'd0);
        checkOutput("bubble_cnt_rst", bubbleCnt, 16'd0);
`endif
        #1;
        rst = 1'b1;
        // If PEND survived reset the PC would jump to 0x0040 here
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checkIfid("post_rst", 16'h0001, 1'b1, 16'h0000, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
